// File: rtl/pad_pkg.sv
// -----------------------------------------------------------------------------
// pad_pkg
// Shared definitions for the pad matrix encoder.
//   state_t        : encoder FSM states (2-bit encoding)
//   NUM_PADS       : number of pad key lines
//   CODE_W         : width of the encoded key index
//   DB_CYCLES_DEF  : default debounce length in clock cycles
// -----------------------------------------------------------------------------
package pad_pkg;

    localparam int NUM_PADS      = 8;
    localparam int CODE_W        = 3;
    localparam int DB_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        EMIT     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

endpackage : pad_pkg

// File: rtl/pad_sync2.sv
// -----------------------------------------------------------------------------
// pad_sync2
// Two-flop synchronizer, one independent chain per bit.
//   clk    : destination clock
//   rst    : asynchronous active-high reset, clears both stages to 0
//   d_i    : asynchronous input lines
//   q_o    : synchronized lines (second stage)
// -----------------------------------------------------------------------------
module pad_sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Each line is an unrelated asynchronous source, so each gets its own
    // chain; no attempt is made to keep bits coherent with each other.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    meta_q[gi] <= 1'b0;
                    sync_q[gi] <= 1'b0;
                end else begin
                    meta_q[gi] <= d_i[gi];
                    sync_q[gi] <= meta_q[gi];
                end
            end
        end
    endgenerate

    assign q_o = sync_q;

endmodule : pad_sync2

// File: rtl/pad_encoder8.sv
// -----------------------------------------------------------------------------
// pad_encoder8
// 8-to-3 pad encoder: synchronizes and debounces eight key lines and emits
// one 3-bit code per press over a valid/ready handshake, then waits for all
// keys to be released (and debounced) before accepting another press.
//   clk         : system clock, rising edge
//   rst         : asynchronous active-high reset
//   D1..D8      : raw active-high key lines (D1 -> code 0, D8 -> code 7)
//   Dout        : encoded key index (lowest pressed line wins)
//   Dout_valid  : Dout holds a new press
//   Dout_ready  : consumer accepts Dout
//   Dout_multi  : more than one key was down in the accepted snapshot
//   busy        : FSM is not idle
// -----------------------------------------------------------------------------
module pad_encoder8
    import pad_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              D1,
    input  logic              D2,
    input  logic              D3,
    input  logic              D4,
    input  logic              D5,
    input  logic              D6,
    input  logic              D7,
    input  logic              D8,
    output logic [CODE_W-1:0] Dout,
    output logic              Dout_valid,
    input  logic              Dout_ready,
    output logic              Dout_multi,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // Index of the lowest set bit; scanning downward lets the lowest win.
    function automatic logic [CODE_W-1:0] enc(input logic [NUM_PADS-1:0] x);
        logic [CODE_W-1:0] r;
        r = '0;
        for (int i = NUM_PADS - 1; i >= 0; i--) begin
            if (x[i]) r = CODE_W'(i);
        end
        return r;
    endfunction

    // popcount(x) > 1 is equivalent to x having a set bit besides its lowest.
    function automatic logic multi(input logic [NUM_PADS-1:0] x);
        return (x & (x - NUM_PADS'(1))) != '0;
    endfunction

    logic [NUM_PADS-1:0] keys_raw;
    logic [NUM_PADS-1:0] keys_s;

    assign keys_raw = {D8, D7, D6, D5, D4, D3, D2, D1};

    pad_sync2 #(
        .WIDTH (NUM_PADS)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (keys_raw),
        .q_o (keys_s)
    );

    state_t              state_q, state_d;
    logic [NUM_PADS-1:0] snap_q,  snap_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [CODE_W-1:0]   dout_q,  dout_d;
    logic                multi_q, multi_d;
    logic                valid_q, valid_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            snap_q  <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            multi_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            multi_q <= multi_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        multi_d = multi_q;
        valid_d = valid_q;

        unique case (state_q)
            IDLE: begin
                if (keys_s != '0) begin
                    state_d = DEBOUNCE;
                    snap_d  = keys_s;
                    cnt_d   = '0;
                end
            end

            DEBOUNCE: begin
                if (keys_s == '0) begin
                    // Released before it settled: treat as a glitch.
                    state_d = IDLE;
                end else if (keys_s != snap_q) begin
                    // Key set still changing; restart the stability window.
                    snap_d = keys_s;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    dout_d  = enc(snap_q);
                    multi_d = multi(snap_q);
                    valid_d = 1'b1;
                    state_d = EMIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            EMIT: begin
                // Outputs frozen until the consumer takes the code.
                if (valid_q && Dout_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
            end

            RELEASE: begin
                if (keys_s != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Dout       = dout_q;
    assign Dout_multi = multi_q;
    assign Dout_valid = valid_q;
    assign busy       = (state_q != IDLE);

endmodule : pad_encoder8

// File: tb/tb_pad_encoder8.sv
module tb_pad_encoder8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] keys = 8'h00;
    logic       ready = 1'b0;
    logic [2:0] dout;
    logic       valid;
    logic       multi;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pad_encoder8 #(.DB_CYCLES(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .D1         (keys[0]),
        .D2         (keys[1]),
        .D3         (keys[2]),
        .D4         (keys[3]),
        .D5         (keys[4]),
        .D6         (keys[5]),
        .D7         (keys[6]),
        .D8         (keys[7]),
        .Dout       (dout),
        .Dout_valid (valid),
        .Dout_ready (ready),
        .Dout_multi (multi),
        .busy       (busy)
    );

    typedef struct {
        logic [7:0] keys;
        logic [2:0] code;
        logic       multi;
    } vec_t;

    vec_t vecs[6];

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Release all keys and wait (bounded) for the FSM to return to idle.
    task automatic release_all(input string name);
        int n;
        keys = 8'h00;
        n = 0;
        while (busy && n < 40) begin
            tick(1);
            n++;
        end
        chk({name, " idle after release"}, {7'd0, busy}, 8'd0);
    endtask

    // Press, expect valid exactly after the 7th edge, check code and pulse.
    task automatic press_check(input string name, input logic [7:0] k,
                               input logic [2:0] code, input logic m);
        keys = k;
        tick(6);
        chk({name, " no valid at edge 6"}, {7'd0, valid}, 8'd0);
        tick(1);
        chk({name, " valid at edge 7"}, {7'd0, valid}, 8'd1);
        chk({name, " code"}, {5'd0, dout}, {5'd0, code});
        chk({name, " multi"}, {7'd0, multi}, {7'd0, m});
        tick(1);
        chk({name, " one-cycle pulse"}, {7'd0, valid}, 8'd0);
    endtask

    initial begin
        int seen;
        logic stable;

        vecs[0] = '{8'h20, 3'd5, 1'b0};  // D6
        vecs[1] = '{8'h48, 3'd3, 1'b1};  // D4+D7
        vecs[2] = '{8'h80, 3'd7, 1'b0};  // D8
        vecs[3] = '{8'h01, 3'd0, 1'b0};  // D1
        vecs[4] = '{8'h06, 3'd1, 1'b1};  // D2+D3
        vecs[5] = '{8'hFF, 3'd0, 1'b1};  // all

        // Reset state
        tick(2);
        chk("reset dout",  {5'd0, dout}, 8'd0);
        chk("reset valid", {7'd0, valid}, 8'd0);
        chk("reset multi", {7'd0, multi}, 8'd0);
        chk("reset busy",  {7'd0, busy}, 8'd0);
        rst = 1'b0;
        ready = 1'b1;
        tick(2);

        // Table-driven presses
        foreach (vecs[i]) begin
            press_check($sformatf("vec%0d", i), vecs[i].keys, vecs[i].code, vecs[i].multi);
            if (i == 0) begin
                // Held key must not produce a second code.
                seen = 0;
                for (int c = 0; c < 30; c++) begin
                    tick(1);
                    if (valid) seen++;
                end
                chk("held D6 no repeat", 8'(seen), 8'd0);
            end
            release_all($sformatf("vec%0d", i));
        end

        // Reset mid-DEBOUNCE with D3 held
        keys = 8'h04;
        tick(4);
        chk("D3 in debounce busy", {7'd0, busy}, 8'd1);
        rst = 1'b1;
        #1;
        chk("async reset busy",  {7'd0, busy}, 8'd0);
        chk("async reset valid", {7'd0, valid}, 8'd0);
        chk("async reset dout",  {5'd0, dout}, 8'd0);
        tick(2);
        rst = 1'b0;
        tick(6);
        chk("post-reset no valid at 6", {7'd0, valid}, 8'd0);
        tick(1);
        chk("post-reset valid at 7", {7'd0, valid}, 8'd1);
        chk("post-reset code D3", {5'd0, dout}, 8'd2);
        tick(1);
        release_all("post-reset");

        // Glitch reject: D2 high for 3 cycles
        keys = 8'h02;
        tick(3);
        keys = 8'h00;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            if (valid) seen++;
        end
        chk("glitch no valid", 8'(seen), 8'd0);
        chk("glitch idle", {7'd0, busy}, 8'd0);

        // Bouncing snapshot: D1, then D1|D5 after 4 cycles
        keys = 8'h01;
        tick(4);
        keys = 8'h11;
        tick(6);
        chk("bounce no valid at change+6", {7'd0, valid}, 8'd0);
        tick(1);
        chk("bounce valid at change+7", {7'd0, valid}, 8'd1);
        chk("bounce code", {5'd0, dout}, 8'd0);
        chk("bounce multi", {7'd0, multi}, 8'd1);
        tick(1);
        release_all("bounce");

        // Backpressure: D8 pressed, ready low
        ready = 1'b0;
        keys = 8'h80;
        tick(7);
        chk("bp valid", {7'd0, valid}, 8'd1);
        chk("bp code", {5'd0, dout}, 8'd7);
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c == 5)  keys = 8'h00;
            if (c == 10) keys = 8'h01;
            tick(1);
            if (!valid || dout !== 3'd7 || multi !== 1'b0) stable = 1'b0;
        end
        chk("bp held stable", {7'd0, stable}, 8'd1);
        ready = 1'b1;
        tick(1);
        chk("bp transferred", {7'd0, valid}, 8'd0);
        chk("bp dout kept", {5'd0, dout}, 8'd7);
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            tick(1);
            if (valid) seen++;
        end
        chk("bp D1 blocked in release", 8'(seen), 8'd0);
        chk("bp still busy", {7'd0, busy}, 8'd1);
        release_all("bp");
        press_check("bp re-press D1", 8'h01, 3'd0, 1'b0);
        release_all("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule : tb_pad_encoder8

// File: doc/pad_encoder8.md
Name: pad_encoder8

Overview:
- 8-to-3 encoder for the pad matrix: the inverse of the 3-bit decoder that drives the 8 pad select lines.
- Takes 8 asynchronous one-hot-ish key lines D1..D8 and synchronizes and debounces them.
- Emits one 3-bit code per press through a valid/ready handshake, then waits for full release before accepting the next press.
- Sits between the raw pad inputs and the sequencer/sound-select logic.

Parameters:
- DB_CYCLES, 4, consecutive stable cycles required to accept a press or a release; legal range 2..65535.
- CNT_W, 16, width of the debounce counter; must satisfy 2^CNT_W > DB_CYCLES.

Ports:
- clk  input  1  single system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- D1..D8  input  1 each  raw key lines, active-high, asynchronous to clk. D1 maps to code 0, D8 to code 7, matching the decoder mapping (Din=0 -> D1).
- Dout  output  3  encoded key index.
- Dout_valid  output  1  Dout holds a new press.
- Dout_ready  input  1  consumer accepts Dout.
- Dout_multi  output  1  more than one key was down in the accepted snapshot.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async assert; rst is released synchronously upstream):
  - Sync flops, snapshot and counter cleared to 0; state=IDLE.
  - Dout=3'b000, Dout_valid=0, Dout_multi=0, busy=0.
  - Reset asserted mid-operation aborts any pending code; an unaccepted code is lost.
- Synchronizer: 2 flops per line; keys_s[7:0], with bit0 from D1. Only keys_s is used downstream.
- Priority: the lowest index wins. enc(x) = index of the lowest set bit of x. Dout_multi = popcount(x) > 1.
- FSM IDLE:
  - keys_s != 0 -> DEBOUNCE; snap <= keys_s, cnt <= 0.
- FSM DEBOUNCE:
  - keys_s == 0 -> IDLE (glitch rejected, nothing emitted).
  - keys_s != snap -> snap <= keys_s, cnt <= 0; stay.
  - Otherwise, if cnt == DB_CYCLES-1 -> Dout <= enc(snap), Dout_multi <= multi(snap), Dout_valid <= 1, go to EMIT.
  - Otherwise cnt <= cnt+1.
- FSM EMIT:
  - Dout, Dout_multi and Dout_valid are held stable regardless of key activity.
  - On Dout_valid && Dout_ready at the clock edge: Dout_valid <= 0, cnt <= 0, go to RELEASE. Dout keeps its last value.
  - Ready asserted in the same cycle valid first rises counts as a transfer at the next edge (one-cycle valid minimum).
- FSM RELEASE:
  - keys_s != 0 -> cnt <= 0.
  - Otherwise, if cnt == DB_CYCLES-1 -> IDLE.
  - Otherwise cnt <= cnt+1.
  - Keys pressed during RELEASE are not reported until all keys are released and debounced.
- Latency: with the lines stable from before edge 0, Dout_valid is high after edge DB_CYCLES+3 (2 sync + 1 IDLE + DB_CYCLES).
- Minimum gap between accepted codes: transfer edge + DB_CYCLES + 1 (RELEASE) + DB_CYCLES+3.
- Counter never wraps; it is reset on every transition into DEBOUNCE/RELEASE and on instability.
- A key held forever yields exactly one code.

Decomposition:
- Shared package pad_pkg holds:
  - state enum {IDLE, DEBOUNCE, EMIT, RELEASE} as 2-bit encoding.
  - NUM_PADS=8 and CODE_W=3.
  - DB_CYCLES default constant.
- One sub-module: pad_sync2, a 2-flop synchronizer parameterized by width, with async active-high reset to 0.
- Priority encode and popcount>1 are combinational functions inside pad_encoder8.

Test Plan:
- Reset: assert rst mid-DEBOUNCE with D3 held -> all outputs 0 immediately, state IDLE; after release, press still down -> Dout=3'd2 valid after DB_CYCLES+3 edges.
- Single press: D6 high, Dout_ready=1, DB_CYCLES=4 -> Dout_valid rises after edge 7 with Dout=3'd5, Dout_multi=0, one-cycle pulse; no second code while D6 stays held.
- Glitch reject: D2 high for 3 cycles then low -> Dout_valid never asserts, busy returns low.
- Multi-key: D4 and D7 high together -> Dout=3'd3, Dout_multi=1.
- Bouncing snapshot: D1 then D1|D5 at cycle 4 -> debounce restarts; Dout=3'd0, Dout_multi=1, valid at (change edge)+DB_CYCLES+3.
- Backpressure: Dout_ready=0 for 20 cycles with D8 pressed, released and D1 pressed meanwhile -> Dout=3'd7 held stable; on ready, transfer; D1 is not reported until all keys are released for DB_CYCLES, then re-pressed.
